// File: rtl/fwd_hazard_unit.sv
// Forwarding selects and load-use stall from shadow EX/MEM/WB destination state.
// Optional FWD_HAZARD_STATS_EN adds saturating stall/forward event counters.
module fwd_hazard_unit #(
  parameter int NUM_SRC  = 2,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [NUM_SRC*AW-1:0]  id_src,
  input  logic [NUM_SRC-1:0]     id_src_used,
  input  logic [AW-1:0]          id_dst,
  input  logic                   id_wen,
  input  logic                   id_is_load,
  input  logic                   flush,
  output logic                   stall,
  output logic [2*NUM_SRC-1:0]   fwd_sel
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]            stat_stall_cycles,
  output logic [31:0]            stat_fwd_events
`endif
);

  typedef struct packed {
    logic          valid;
    logic          wen;
    logic [AW-1:0] dst;
  } wr_t;

  typedef enum logic {IDLE, HOLD} st_e;

  localparam logic [2:0] HOLD_INIT = 3'(LOAD_LAT - 1);

  wr_t                  ex_q, ex_d, mem_q, wb_q;
  logic                 ex_load_q, ex_load_d;
  logic [NUM_SRC*AW-1:0] ex_src_q, ex_src_d;
  logic [NUM_SRC-1:0]   ex_used_q, ex_used_d;
  st_e                  st_q, st_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 hazard;
  logic                 take;

  function automatic logic is_wr(wr_t s);
    return s.valid && s.wen && (s.dst != '0);
  endfunction

  // Youngest producer (MEM) wins over WB
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_used_q[i] && is_wr(mem_q) &&
          mem_q.dst == ex_src_q[i*AW +: AW])
        fwd_sel[2*i +: 2] = 2'b01;
      else if (ex_used_q[i] && is_wr(wb_q) &&
               wb_q.dst == ex_src_q[i*AW +: AW])
        fwd_sel[2*i +: 2] = 2'b10;
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] && id_src[i*AW +: AW] == ex_q.dst)
        hazard = 1'b1;
    end
    hazard = hazard && id_valid && !flush &&
             is_wr(ex_q) && ex_load_q;
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    stall = 1'b0;
    unique case (st_q)
      IDLE: begin
        stall = hazard;
        if (hazard && LOAD_LAT > 1) begin
          st_d  = HOLD;
          cnt_d = HOLD_INIT;
        end
      end
      HOLD: begin
        stall = 1'b1;
        if (cnt_q <= 3'd1) begin
          st_d  = IDLE;
          cnt_d = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        st_d  = IDLE;
        cnt_d = 3'd0;
      end
    endcase
    if (flush) begin
      st_d  = IDLE;
      cnt_d = 3'd0;
    end
  end

  // Bubbles clear every EX field so a dead slot never forwards
  always_comb begin
    take      = id_valid && !stall && !flush;
    ex_d      = '0;
    ex_load_d = 1'b0;
    ex_src_d  = '0;
    ex_used_d = '0;
    if (take) begin
      ex_d.valid = 1'b1;
      ex_d.wen   = id_wen;
      ex_d.dst   = id_dst;
      ex_load_d  = id_is_load;
      ex_src_d   = id_src;
      ex_used_d  = id_src_used;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      ex_load_q <= 1'b0;
      ex_src_q  <= '0;
      ex_used_q <= '0;
      st_q      <= IDLE;
      cnt_q     <= 3'd0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      ex_load_q <= ex_load_d;
      ex_src_q  <= ex_src_d;
      ex_used_q <= ex_used_d;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] sc_q, fe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q <= '0;
      fe_q <= '0;
    end else begin
      if (stall && sc_q != '1)
        sc_q <= sc_q + 32'd1;
      if ((|fwd_sel) && fe_q != '1)
        fe_q <= fe_q + 32'd1;
    end
  end

  assign stat_stall_cycles = sc_q;
  assign stat_fwd_events   = fe_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with LOAD_LAT=1 and LOAD_LAT=3 instances.
// Counter checks are compiled in when FWD_HAZARD_STATS_EN is defined.
module tb_fwd_hazard_unit;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [9:0] id_src;
  logic [1:0] id_src_used;
  logic [4:0] id_dst;
  logic       id_wen;
  logic       id_is_load;
  logic       flush;
  logic       st1, st3;
  logic [3:0] fw1, fw3;
`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] sc1, fe1, sc3, fe3;
`endif

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit #(.NUM_SRC(2), .AW(5), .LOAD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dst(id_dst), .id_wen(id_wen),
    .id_is_load(id_is_load), .flush(flush), .stall(st1),
    .fwd_sel(fw1)
`ifdef FWD_HAZARD_STATS_EN
    , .stat_stall_cycles(sc1), .stat_fwd_events(fe1)
`endif
  );

  fwd_hazard_unit #(.NUM_SRC(2), .AW(5), .LOAD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dst(id_dst), .id_wen(id_wen),
    .id_is_load(id_is_load), .flush(flush), .stall(st3),
    .fwd_sel(fw3)
`ifdef FWD_HAZARD_STATS_EN
    , .stat_stall_cycles(sc3), .stat_fwd_events(fe3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r, v;
    logic [4:0] s0, s1;
    logic [1:0] u;
    logic [4:0] d;
    logic       w, l, f;
    logic       m1, st1;
    logic [3:0] f1;
    logic       m3, st3;
    logic [3:0] f3;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(int r, int v, int s0, int s1, int u,
                              int d, int w, int l, int f,
                              int m1, int e1, int f1,
                              int m3, int e3, int f3);
    vec_t x;
    x.r = r[0];  x.v = v[0];
    x.s0 = 5'(s0); x.s1 = 5'(s1);
    x.u = 2'(u); x.d = 5'(d);
    x.w = w[0]; x.l = l[0]; x.f = f[0];
    x.m1 = m1[0]; x.st1 = e1[0]; x.f1 = 4'(f1);
    x.m3 = m3[0]; x.st3 = e3[0]; x.f3 = 4'(f3);
    return x;
  endfunction

  task automatic chk(string nm, int row, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, a, e);
    end
  endtask

  task automatic drv(int r, int v, int s0, int s1, int u,
                     int d, int w, int l, int f);
    rst         = r[0];
    id_valid    = v[0];
    id_src      = {5'(s1), 5'(s0)};
    id_src_used = 2'(u);
    id_dst      = 5'(d);
    id_wen      = w[0];
    id_is_load  = l[0];
    flush       = f[0];
  endtask

  task automatic nop_cyc();
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_rst();
    @(negedge clk);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    nop_cyc();
  endtask

  task automatic ld_use(input bit sel3, input int exp_len,
                        input logic [3:0] exp_fwd);
    int n;
    logic s;
    do_rst();
    @(negedge clk);
    drv(0, 1, 1, 0, 1, 4, 1, 1, 0);
    @(negedge clk);
    drv(0, 1, 4, 1, 3, 5, 1, 0, 0);
    #1;
    n = 0;
    s = sel3 ? st3 : st1;
    while (s === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
      #1;
      s = sel3 ? st3 : st1;
    end
    chk(sel3 ? "stall_len3" : "stall_len1", n, 32'(n), 32'(exp_len));
    nop_cyc();
    #1;
    chk(sel3 ? "fwd_after3" : "fwd_after1", 0,
        32'(sel3 ? fw3 : fw1), 32'(exp_fwd));
  endtask

  initial begin
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // ALU chain add $2,$2,$3 x4
    tv.push_back(mk(1,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0,0));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,1, 2,3,3, 2,1,0,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,1, 2,3,3, 2,1,0,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,1, 2,3,3, 2,1,0,0, 1,0,1, 1,0,1));
    tv.push_back(mk(0,1, 2,3,3, 2,1,0,0, 1,0,1, 1,0,1));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 1,0,1, 1,0,1));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 1,0,0, 1,0,0));
    // load-use, LOAD_LAT=1
    tv.push_back(mk(1,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0,0));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,1, 1,0,1, 4,1,1,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,1, 4,1,3, 5,1,0,0, 1,1,0, 1,1,0));
    tv.push_back(mk(0,1, 4,1,3, 5,1,0,0, 1,0,0, 0,0,0));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 1,0,2, 0,0,0));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 1,0,0, 0,0,0));
    // load-use, LOAD_LAT=3
    tv.push_back(mk(1,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0,0));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,1, 1,0,1, 4,1,1,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,1, 4,1,3, 5,1,0,0, 1,1,0, 1,1,0));
    tv.push_back(mk(0,1, 4,1,3, 5,1,0,0, 0,0,0, 1,1,0));
    tv.push_back(mk(0,1, 4,1,3, 5,1,0,0, 0,0,0, 1,1,0));
    tv.push_back(mk(0,1, 4,1,3, 5,1,0,0, 0,0,0, 1,0,0));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 0,0,0, 1,0,0));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 0,0,0, 1,0,0));
    // $0 writer/reader, unused operand on $7
    tv.push_back(mk(1,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0,0));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,1, 1,1,0, 0,1,1,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,1, 0,0,3, 6,1,0,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,1, 0,0,0, 7,1,1,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,1, 7,7,0, 8,1,0,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 1,0,0, 1,0,0));
    // operand 0 from MEM, operand 1 from WB
    tv.push_back(mk(0,1, 1,1,0, 9,1,0,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,1, 1,1,0, 10,1,0,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,1, 10,9,3, 11,1,0,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 1,0,9, 1,0,9));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 1,0,0, 1,0,0));
    // flush concurrent with hazard
    tv.push_back(mk(0,1, 1,0,1, 4,1,1,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,1, 4,1,3, 5,1,0,1, 1,0,0, 1,0,0));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 1,0,0, 1,0,0));
    // flush in 2nd stall cycle
    tv.push_back(mk(0,1, 1,0,1, 4,1,1,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,1, 4,1,3, 5,1,0,0, 1,1,0, 1,1,0));
    tv.push_back(mk(0,1, 4,1,3, 5,1,0,1, 1,0,0, 1,1,0));
    tv.push_back(mk(0,1, 4,1,3, 5,1,0,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 1,0,0, 1,0,0));
    // rst in 2nd stall cycle
    tv.push_back(mk(0,1, 1,0,1, 4,1,1,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,1, 4,1,3, 5,1,0,0, 1,1,0, 1,1,0));
    tv.push_back(mk(1,1, 4,1,3, 5,1,0,0, 0,0,0, 0,0,0));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 1,0,0, 1,0,0));
    tv.push_back(mk(0,0, 0,0,0, 0,0,0,0, 1,0,0, 1,0,0));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drv(int'(tv[i].r), int'(tv[i].v), int'(tv[i].s0),
          int'(tv[i].s1), int'(tv[i].u), int'(tv[i].d),
          int'(tv[i].w), int'(tv[i].l), int'(tv[i].f));
      #1;
      if (tv[i].m1) begin
        chk("stall_L1", i, 32'(st1), 32'(tv[i].st1));
        chk("fwd_L1", i, 32'(fw1), 32'(tv[i].f1));
      end
      if (tv[i].m3) begin
        chk("stall_L3", i, 32'(st3), 32'(tv[i].st3));
        chk("fwd_L3", i, 32'(fw3), 32'(tv[i].f3));
      end
    end

    ld_use(1'b0, 1, 4'b0010);
    ld_use(1'b1, 3, 4'b0000);

`ifdef FWD_HAZARD_STATS_EN
    do_rst();
    #1;
    chk("stat_stall_rst", 0, sc1, 32'd0);
    chk("stat_fwd_rst", 0, fe1, 32'd0);
    @(negedge clk); drv(0, 1, 1, 0, 1, 4, 1, 1, 0);
    @(negedge clk); drv(0, 1, 4, 1, 3, 5, 1, 0, 0);
    @(negedge clk); drv(0, 1, 4, 1, 3, 5, 1, 0, 0);
    @(negedge clk); drv(0, 1, 2, 3, 3, 2, 1, 0, 0);
    @(negedge clk); drv(0, 1, 2, 3, 3, 2, 1, 0, 0);
    @(negedge clk); drv(0, 1, 2, 3, 3, 2, 1, 0, 0);
    nop_cyc();
    nop_cyc();
    #1;
    chk("stat_stall", 1, sc1, 32'd1);
    chk("stat_fwd", 1, fe1, 32'd3);
    do_rst();
    #1;
    chk("stat_stall_rst2", 2, sc1, 32'd0);
    chk("stat_fwd_rst2", 2, fe1, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
